gpio_pad_arbiter: RTL and testbench
===================================

# gpio_pad_arbiter

Round-robin arbiter and sequencer for the shared 32-bit bidirectional GPIO pad bus. It grants exclusive drive ownership to one of `NUM_REQ` requesters at a time and registers that owner's per-bit data and enable onto `io_out`/`io_en`. It inserts a one-cycle all-hi-Z turnaround on every ownership handoff and returns a registered sample of the pad bus to all requesters. It sits between the internal pad drivers and the per-bit tri-state buffers on `io_pad`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 32: pad bus width.
- `MAX_HOLD`, 16: OWN cycles after which the owner is preempted if another requester is pending (≥2).

Ports:
- `PCLK` in 1: single clock, all state on posedge.
- `PRESET` in 1: reset, synchronous, active-high.
- `req` in NUM_REQ: request per requester; held high while ownership is wanted.
- `req_out` in NUM_REQ*WIDTH: flattened drive data; slice k = requester k.
- `req_en` in NUM_REQ*WIDTH: flattened per-bit drive enable; slice k = requester k.
- `io_pad` in WIDTH: resolved pad bus.
- `io_out` out WIDTH: registered drive data to the pad buffers.
- `io_en` out WIDTH: registered per-bit enable; bit i drives `io_pad[i]` when 1, otherwise hi-Z.
- `gnt` out NUM_REQ: one-hot grant, registered; all-zero outside OWN.
- `owner` out $clog2(NUM_REQ): index of current or last owner.
- `pad_in` out WIDTH: `io_pad` registered once.
- `busy` out 1: high in OWN or TURN.

## Operation
States:
- **IDLE**: bus released.
  - Any `req` → OWN with the round-robin winner.
- **OWN**: the winner holds the bus.
  - Owner's `req` low → TURN.
  - Hold counter at `MAX_HOLD-1` with any other `req` high → TURN (preemption).
  - Otherwise stay in OWN.
  - Hold counter saturates while no other requester is pending.
- **TURN**: exactly one cycle; `io_en`=0, `gnt`=0.
  - Re-arbitrate among current `req`: winner → OWN, none → IDLE.
  - A preempted owner still requesting competes normally. It has lowest priority because the pointer has passed it.

Arbitration and datapath:
- Round-robin priority starts at `ptr+1` mod `NUM_REQ`. `ptr` is updated to the winner on every grant.
- Reset `ptr`=`NUM_REQ-1`, so requester 0 wins first.
- When next state is OWN: `io_out`/`io_en` load the `req_out`/`req_en` slice of the next owner every cycle. The owner may change data and enable freely while it holds the bus.
- Otherwise `io_out`=0 and `io_en`=0.
- `pad_in` updates every cycle regardless of state. Undriven bits carry whatever the pad resolves to.
- Hold counter clears on every entry to OWN.

Reset values: state IDLE, `io_out`=0, `io_en`=0, `gnt`=0, `owner`=0, `pad_in`=0, `busy`=0, `ptr`=`NUM_REQ-1`, hold counter 0.

## Timing
- `req` rising at edge t from IDLE: `gnt` and `io_en` valid after edge t+1. Latency is 1 cycle.
- Owner data change sampled at edge t appears on `io_out` after edge t+1.
- Release at edge t: `io_en`=0 after t+1 (TURN). The next owner's enable appears after t+2. No cycle ever has two drivers.
- Preemption: the owner has exactly `MAX_HOLD` OWN cycles, then 1 TURN cycle.
- A requester dropping `req` in the same cycle it would be granted is not granted. Arbitration uses the live `req` only.
- `PRESET` mid-OWN or mid-TURN: at the next edge all outputs return to reset values, independent of `req`.
- `PRESET` has priority over every transition.
- `pad_in` lags `io_pad` by 1 cycle.

## Structure
- `gpio_arb_pkg`:
  - state enum (IDLE/OWN/TURN)
  - default `WIDTH`/`NUM_REQ` localparams
  - slice-index helper function for the flattened buses
- Sub-module `gpio_rr_picker`: combinational. Takes `req` and `ptr`; returns `valid` and the winner index, with rotated-priority search. It is instantiated once.
- The top level holds the FSM, hold counter, pointer and output registers.

## Test plan
- Single requester: `req[2]`=1, `req_out[2]`=0xA5A5_0000, `req_en[2]`=0xFFFF_0000 → after 1 cycle `gnt`=4'b0100 and `io_en`=0xFFFF_0000. Drop `req` → 1 TURN cycle with `io_en`=0, then IDLE with `busy`=0.
- All four `req` high after reset, each dropping after 3 OWN cycles → grant order 0,1,2,3. One `io_en`=0 cycle between each pair of owners. `gnt` is never multi-hot.
- Preemption (`MAX_HOLD`=16): `req[0]` held, `req[1]` asserted at OWN cycle 2 → `gnt[0]` high for exactly 16 cycles, then TURN, then `gnt`=4'b0010.
- Sole holder: `req[3]` held for 100 cycles with no other request → continuous OWN, no TURN, `io_en` tracks `req_en[3]` with 1-cycle lag.
- `PRESET` pulsed during OWN of requester 2 → next edge `io_en`=0, `gnt`=0, IDLE. With all `req` high afterward, requester 0 wins first.
- Bench drives 0x1234_5678 onto `io_pad` while `io_en`=0 → `pad_in`=0x1234_5678 one cycle later. Contention assertion throughout: `io_en`≠0 never occurs in TURN or IDLE.

Source files
------------

// File: rtl/gpio_arb_pkg.sv
// Shared types, defaults and helpers for the GPIO pad arbiter.
// Used by the round-robin picker and by the top-level sequencer.
package gpio_arb_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_NUM_REQ = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_TURN = 2'd2
   } arb_state_e;

   // Low bit of requester idx's slice within a flattened NUM_REQ*width bus.
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/gpio_rr_picker.sv
// Combinational round-robin picker.
// Searches req starting at ptr+1 (mod NUM_REQ) and returns the first requester found.
module gpio_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic               valid_o,
   output logic [IW-1:0]      idx_o
);

   logic [IW-1:0] cand;

   // Walk from the farthest offset down to ptr+1 so the nearest hit is written last and wins.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = IW'((int'(ptr_i) + k) % NUM_REQ);
         if (req_i[cand]) begin
            valid_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/gpio_pad_arbiter.sv
// Round-robin owner sequencer for the shared GPIO pad bus.
// Grants one requester at a time, registers its drive data/enable and inserts a hi-Z turnaround cycle.
module gpio_pad_arbiter
   import gpio_arb_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MAX_HOLD = 16
) (
   input  logic                       PCLK,
   input  logic                       PRESET,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   req_out,
   input  logic [NUM_REQ*WIDTH-1:0]   req_en,
   input  logic [WIDTH-1:0]           io_pad,
   output logic [WIDTH-1:0]           io_out,
   output logic [WIDTH-1:0]           io_en,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic [WIDTH-1:0]           pad_in,
   output logic                       busy
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int HW = $clog2(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   arb_state_e         state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [IW-1:0]      owner_q, owner_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [WIDTH-1:0]   io_out_q, io_en_q, pad_in_q;
   logic [NUM_REQ-1:0] gnt_q;

   logic               pick_valid;
   logic [IW-1:0]      pick_idx;
   logic [NUM_REQ-1:0] owner_oh;
   logic               others_pending;
   logic               hold_at_last;

   logic [WIDTH-1:0]   out_arr [NUM_REQ];
   logic [WIDTH-1:0]   en_arr  [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         localparam int LO = slice_lo(gi, WIDTH);
         assign out_arr[gi]  = req_out[LO +: WIDTH];
         assign en_arr[gi]   = req_en[LO +: WIDTH];
         assign owner_oh[gi] = (owner_q == IW'(gi));
      end
   endgenerate

   gpio_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_picker (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   assign others_pending = |(req & ~owner_oh);
   assign hold_at_last   = (hold_q == HOLD_LAST);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE, ST_TURN: begin
            if (pick_valid) begin
               state_d = ST_OWN;
               owner_d = pick_idx;
               ptr_d   = pick_idx;
               hold_d  = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_OWN: begin
            if (!req[owner_q]) begin
               state_d = ST_TURN;
            end else if (hold_at_last && others_pending) begin
               state_d = ST_TURN;
            end else if (!hold_at_last) begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath follows the next state so grant and drive appear together, one cycle after the request.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q  <= ST_IDLE;
         ptr_q    <= IW'(NUM_REQ - 1);
         owner_q  <= '0;
         hold_q   <= '0;
         io_out_q <= '0;
         io_en_q  <= '0;
         gnt_q    <= '0;
         pad_in_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         hold_q   <= hold_d;
         pad_in_q <= io_pad;
         if (state_d == ST_OWN) begin
            io_out_q <= out_arr[owner_d];
            io_en_q  <= en_arr[owner_d];
            gnt_q    <= NUM_REQ'(1) << owner_d;
         end else begin
            io_out_q <= '0;
            io_en_q  <= '0;
            gnt_q    <= '0;
         end
      end
   end

   assign io_out = io_out_q;
   assign io_en  = io_en_q;
   assign gnt    = gnt_q;
   assign owner  = owner_q;
   assign pad_in = pad_in_q;
   assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpio_pad_arbiter.sv
// Directed bench for gpio_pad_arbiter with a per-cycle expectation queue.
// A negedge monitor checks single ownership and that the bus is never driven without a grant.
module tb_gpio_pad_arbiter;

   localparam int NR = 4;
   localparam int W  = 32;
   localparam int MH = 16;

   logic              PCLK = 1'b0;
   logic              PRESET;
   logic [NR-1:0]     req;
   logic [W-1:0]      d_out [NR];
   logic [W-1:0]      d_en  [NR];
   logic [NR*W-1:0]   req_out;
   logic [NR*W-1:0]   req_en;
   logic [W-1:0]      pad_drv;
   logic [W-1:0]      io_out;
   logic [W-1:0]      io_en;
   logic [NR-1:0]     gnt;
   logic [1:0]        owner;
   logic [W-1:0]      pad_in;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   typedef struct {
      string       tag;
      logic [3:0]  g;
      logic [31:0] en;
      logic [31:0] o;
      logic        b;
      logic [1:0]  own;
   } exp_t;

   exp_t sbq[$];

   genvar gi;
   generate
      for (gi = 0; gi < NR; gi++) begin : g_pack
         assign req_out[gi*W +: W] = d_out[gi];
         assign req_en[gi*W +: W]  = d_en[gi];
      end
   endgenerate

   gpio_pad_arbiter #(
      .NUM_REQ  (NR),
      .WIDTH    (W),
      .MAX_HOLD (MH)
   ) dut (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .req     (req),
      .req_out (req_out),
      .req_en  (req_en),
      .io_pad  (pad_drv),
      .io_out  (io_out),
      .io_en   (io_en),
      .gnt     (gnt),
      .owner   (owner),
      .pad_in  (pad_in),
      .busy    (busy)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Queue the expected post-edge outputs, advance one edge, then pop and compare.
   task automatic cyc(input string tag, input logic [3:0] g, input logic [31:0] en,
                      input logic [31:0] o, input logic b, input logic [1:0] own);
      exp_t e;
      e.tag = tag; e.g = g; e.en = en; e.o = o; e.b = b; e.own = own;
      sbq.push_back(e);
      @(posedge PCLK);
      #1;
      e = sbq.pop_front();
      $display("txn %s gnt=%b io_en=%h io_out=%h busy=%b owner=%0d", e.tag, gnt, io_en, io_out, busy, owner);
      chk({e.tag, ".gnt"},    32'(gnt),   32'(e.g));
      chk({e.tag, ".io_en"},  io_en,      e.en);
      chk({e.tag, ".io_out"}, io_out,     e.o);
      chk({e.tag, ".busy"},   32'(busy),  32'(e.b));
      chk({e.tag, ".owner"},  32'(owner), 32'(e.own));
   endtask

   task automatic do_reset(input string tag);
      PRESET = 1'b1;
      cyc(tag, 4'b0000, 32'h0, 32'h0, 1'b0, 2'd0);
      PRESET = 1'b0;
   endtask

   always @(negedge PCLK) begin
      if (mon_en) begin
         n_checks++;
         assert (($onehot0(gnt) && ((io_en == '0) || (gnt != '0)) && ((gnt == '0) || busy)) === 1'b1) else begin
            n_fail++;
            $error("FAIL contention gnt=%b io_en=%h busy=%b required onehot0 grant and no drive without grant", gnt, io_en, busy);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      PRESET   = 1'b1;
      req      = '0;
      pad_drv  = 32'hDEAD_BEEF;
      d_out[0] = 32'h0000_00F0; d_en[0] = 32'h0000_00FF;
      d_out[1] = 32'h0000_BE00; d_en[1] = 32'h0000_FF00;
      d_out[2] = 32'hA5A5_0000; d_en[2] = 32'hFFFF_0000;
      d_out[3] = 32'h0505_0505; d_en[3] = 32'h0F0F_0F0F;

      // Reset state; pad_in must be cleared even though the pad carries a value.
      do_reset("reset");
      chk("reset.pad_in", pad_in, 32'h0);
      mon_en = 1'b1;

      // Single requester 2, mid-ownership data change, release, turnaround, idle.
      req = 4'b0100;
      cyc("s1_grant", 4'b0100, 32'hFFFF_0000, 32'hA5A5_0000, 1'b1, 2'd2);
      d_out[2] = 32'hA5A5_5A5A;
      cyc("s1_data",  4'b0100, 32'hFFFF_0000, 32'hA5A5_5A5A, 1'b1, 2'd2);
      req = 4'b0000;
      pad_drv = 32'h1234_5678;
      cyc("s1_turn",  4'b0000, 32'h0, 32'h0, 1'b1, 2'd2);
      chk("s1.pad_in", pad_in, 32'h1234_5678);
      cyc("s1_idle",  4'b0000, 32'h0, 32'h0, 1'b0, 2'd2);
      d_out[2] = 32'hA5A5_0000;

      // All four requesting from reset: order 0,1,2,3 with a turnaround between owners.
      do_reset("s2_reset");
      req = 4'b1111;
      for (int k = 0; k < NR; k++) begin
         for (int c = 0; c < 3; c++)
            cyc($sformatf("s2_own%0d_c%0d", k, c), 4'(1 << k), d_en[k], d_out[k], 1'b1, 2'(k));
         req[k] = 1'b0;
         cyc($sformatf("s2_turn%0d", k), 4'b0000, 32'h0, 32'h0, 1'b1, 2'(k));
      end
      cyc("s2_idle", 4'b0000, 32'h0, 32'h0, 1'b0, 2'd3);

      // Preemption: requester 0 keeps the bus for exactly MAX_HOLD cycles once requester 1 waits.
      do_reset("s3_reset");
      req = 4'b0001;
      for (int i = 1; i <= MH; i++) begin
         if (i == 2) req = 4'b0011;
         cyc($sformatf("s3_own0_c%0d", i), 4'b0001, d_en[0], d_out[0], 1'b1, 2'd0);
      end
      cyc("s3_turn",  4'b0000, 32'h0, 32'h0, 1'b1, 2'd0);
      cyc("s3_own1",  4'b0010, d_en[1], d_out[1], 1'b1, 2'd1);
      req = 4'b0000;
      cyc("s3_turn1", 4'b0000, 32'h0, 32'h0, 1'b1, 2'd1);
      cyc("s3_idle",  4'b0000, 32'h0, 32'h0, 1'b0, 2'd1);

      // Sole holder for 100 cycles with changing enables, then a saturated counter preempts at once.
      do_reset("s4_reset");
      req = 4'b1000;
      for (int i = 0; i < 100; i++) begin
         d_en[3]  = $urandom;
         d_out[3] = $urandom;
         cyc($sformatf("s4_own3_c%0d", i), 4'b1000, d_en[3], d_out[3], 1'b1, 2'd3);
      end
      req = 4'b1001;
      cyc("s4_preempt", 4'b0000, 32'h0, 32'h0, 1'b1, 2'd3);
      cyc("s4_own0",    4'b0001, d_en[0], d_out[0], 1'b1, 2'd0);

      // Reset during ownership of requester 2 wins over a live request.
      req = 4'b0100;
      cyc("s5_turn", 4'b0000, 32'h0, 32'h0, 1'b1, 2'd0);
      cyc("s5_own2", 4'b0100, d_en[2], d_out[2], 1'b1, 2'd2);
      pad_drv = 32'hCAFE_0001;
      do_reset("s5_reset_mid_own");
      chk("s5.pad_in_after_reset", pad_in, 32'h0);
      req = 4'b1111;
      cyc("s5_own0", 4'b0001, d_en[0], d_out[0], 1'b1, 2'd0);
      chk("s5.pad_in", pad_in, 32'hCAFE_0001);
      req = 4'b0000;
      cyc("s5_turn0", 4'b0000, 32'h0, 32'h0, 1'b1, 2'd0);
      cyc("s5_idle",  4'b0000, 32'h0, 32'h0, 1'b0, 2'd0);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
